// File: rtl/spi_slave_stream.sv
// SPI mode-0 slave. The SPI pins are oversampled on clk, and whole words are exchanged with local
// logic over valid/ready streams.
module spi_slave_stream #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  rx_overrun
);

  localparam int unsigned    CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  // One extra registered stage after the synchronizers, so the edge detect is registered.
  logic sclk_q, sclk_prev_q, cs_q, cs_prev_q, mosi_q;

  logic [CntW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-2:0] tx_shift_q;  // bits still to send after the one on spi_miso
  logic [DATA_WIDTH-2:0] rx_shift_q;
  logic                  miso_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  buf_full_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  underrun_q, overrun_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic select, deselect, load_word, shift_out, rx_shift_en, word_done;
  logic [DATA_WIDTH-1:0] next_word, rx_word;

  assign sclk_rise = sclk_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q & sclk_prev_q;
  assign cs_fall   = ~cs_q & cs_prev_q;
  assign cs_rise   = cs_q & ~cs_prev_q;
  assign next_word = buf_full_q ? buf_q : IDLE_WORD;
  assign rx_word   = {rx_shift_q, mosi_q};

  always_comb begin
    state_d     = state_q;
    select      = 1'b0;
    deselect    = 1'b0;
    load_word   = 1'b0;
    shift_out   = 1'b0;
    rx_shift_en = 1'b0;
    word_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StActive;
          select    = 1'b1;
          load_word = 1'b1;
        end
      end
      StActive: begin
        // Deselect wins over any coincident clock edge.
        if (cs_rise) begin
          state_d  = StIdle;
          deselect = 1'b1;
        end else if (sclk_rise) begin
          rx_shift_en = 1'b1;
          word_done   = (bit_cnt_q == LastBit);
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) load_word = 1'b1;
          else                 shift_out = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_q      <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_q        <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_q      <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      miso_q      <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_q      <= sclk_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_q;
      cs_q        <= cs_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_q;
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];

      state_q    <= state_d;
      underrun_q <= load_word & ~buf_full_q;
      overrun_q  <= word_done & rx_valid_q & ~rx_ready;

      // A load into an empty buffer may coincide with a word load, which then takes IDLE_WORD.
      if (tx_valid && !buf_full_q) begin
        buf_q      <= tx_data;
        buf_full_q <= 1'b1;
      end else if (load_word) begin
        buf_full_q <= 1'b0;
      end

      if (load_word) begin
        tx_shift_q <= next_word[DATA_WIDTH-2:0];
        miso_q     <= next_word[DATA_WIDTH-1];
      end
      if (shift_out) begin
        miso_q     <= tx_shift_q[DATA_WIDTH-2];
        tx_shift_q <= tx_shift_q << 1;
      end

      if (select) bit_cnt_q <= '0;
      if (rx_shift_en) begin
        rx_shift_q <= rx_word[DATA_WIDTH-2:0];
        bit_cnt_q  <= word_done ? '0 : bit_cnt_q + 1'b1;
      end

      if (word_done) begin
        rx_data_q  <= rx_word;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (deselect) begin
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end
    end
  end

  assign busy        = (state_q == StActive);
  assign spi_miso_oe = busy;
  assign spi_miso    = miso_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;

endmodule
